window_gen_3x3: RTL

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

---
 rtl/canny_pkg.sv | 11 +
 rtl/line_buffer.sv | 24 ++
 rtl/window_gen_3x3.sv | 132 +++++++++++++
 3 files changed

// File: rtl/canny_pkg.sv
// Shared defaults and FSM encodings for the canny pipeline blocks.
package canny_pkg;

    localparam int PIX_W_DEF      = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/line_buffer.sv
// Single-line pixel store; asynchronous read returns the old word
// at addr, so a same-address write is read-before-write.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-scan 3x3 window generator, valid windows only, 1-cycle latency.
// Optional window-centre coordinates with WINDOW_COORD_EN.
module window_gen_3x3
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    output logic [PIX_W-1:0] p00,
    output logic [PIX_W-1:0] p01,
    output logic [PIX_W-1:0] p02,
    output logic [PIX_W-1:0] p10,
    output logic [PIX_W-1:0] p11,
    output logic [PIX_W-1:0] p12,
    output logic [PIX_W-1:0] p20,
    output logic [PIX_W-1:0] p21,
    output logic [PIX_W-1:0] p22,
    output logic             out_valid,
    output logic             frame_done
`ifdef WINDOW_COORD_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_y
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]    col, ce, col_nx;
    logic [RW-1:0]    row, re, row_nx;
    logic [0:0]       state, state_nx;
    logic [PIX_W-1:0] lb1_q, lb2_q;
    logic [PIX_W-1:0] r0 [3];
    logic [PIX_W-1:0] r1 [3];
    logic [PIX_W-1:0] r2 [3];
    logic             sof, last_col, last_row, win;

    // A qualified sof forces this pixel to (0,0) before counting.
    always_comb begin
        sof      = in_valid & in_sof;
        ce       = sof ? '0 : col;
        re       = sof ? '0 : row;
        last_col = (ce == CW'(IMG_WIDTH - 1));
        last_row = (re == RW'(IMG_HEIGHT - 1));
        col_nx   = last_col ? '0 : ce + CW'(1);
        row_nx   = re;
        if (last_col) begin
            row_nx = last_row ? '0 : re + RW'(1);
        end
        state_nx = (row_nx >= RW'(2)) ? ST_RUN : ST_FILL;
        win      = in_valid & ~sof & (state == ST_RUN)
                 & (ce >= CW'(2));
    end

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (ce),
        .wdata (in_pixel),
        .rdata (lb1_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb2 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (ce),
        .wdata (lb1_q),
        .rdata (lb2_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            state      <= ST_FILL;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r0[i] <= '0;
                r1[i] <= '0;
                r2[i] <= '0;
            end
        end else begin
            out_valid  <= win;
            frame_done <= win & last_col & last_row;
            if (in_valid) begin
                col   <= col_nx;
                row   <= row_nx;
                state <= state_nx;
                r0[0] <= r0[1];
                r0[1] <= r0[2];
                r0[2] <= lb2_q;
                r1[0] <= r1[1];
                r1[1] <= r1[2];
                r1[2] <= lb1_q;
                r2[0] <= r2[1];
                r2[1] <= r2[2];
                r2[2] <= in_pixel;
            end
        end
    end

    assign p00 = r0[0];
    assign p01 = r0[1];
    assign p02 = r0[2];
    assign p10 = r1[0];
    assign p11 = r1[1];
    assign p12 = r1[2];
    assign p20 = r2[0];
    assign p21 = r2[1];
    assign p22 = r2[2];

`ifdef WINDOW_COORD_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_x <= '0;
            out_y <= '0;
        end else if (win) begin
            out_x <= ce - CW'(1);
            out_y <= re - RW'(1);
        end
    end
`endif

endmodule
